// File: rtl/wb_text_ram_pkg.sv
// Shared constants and types for the text-mode cell buffer.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  // Register offsets inside the register region (adr[13]=1, offset adr[2:0])
  localparam logic [2:0] REG_MODE   = 3'd0;
  localparam logic [2:0] REG_CURSOR = 3'd1;
  localparam logic [2:0] REG_DATA   = 3'd2;
  localparam logic [2:0] REG_CLEAR  = 3'd3;

  // Clear engine states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } clr_state_e;

  // Saturate a written cursor value to the last valid cell index.
  function automatic logic [ADDR_W-1:0] clamp_index(input logic [31:0] value,
                                                    input logic [ADDR_W-1:0] last);
    if (value > {{(32-ADDR_W){1'b0}}, last}) begin
      return last;
    end
    return value[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/wb_text_ram_dpram.sv
// Character/attribute cell memory: port A read/write with per-byte enables,
// port B read-only for the video fetch. Both reads are registered and
// read-before-write, so a same-cycle write never leaks into either read.
module char_attr_dpram
  import text_pkg::*;
(
  input  logic              clk,
  input  logic [1:0]        a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic [15:0]       a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [15:0]       b_rdata
);

  // Lane 0 holds the character byte, lane 1 the attribute byte.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] a_q;
    logic [7:0] b_q;

    // Port A: byte-lane write plus registered read of the old contents
    always_ff @(posedge clk) begin
      if (a_we[gi]) begin
        mem[a_addr] <= a_wdata[gi*8 +: 8];
      end
      a_q <= mem[a_addr];
    end

    // Port B: registered read for the video side
    always_ff @(posedge clk) begin
      b_q <= mem[b_addr];
    end

    assign a_rdata[gi*8 +: 8] = a_q;
    assign b_rdata[gi*8 +: 8] = b_q;
  end

endmodule

// File: rtl/wb_text_ram.sv
// Wishbone slave owning the 80x30 text cell buffer, with a cursor/data
// register pair, a hardware clear engine and the video fetch port.
module wb_text_ram #(
  parameter int          COLS           = 80,
  parameter int          ROWS           = 30,
  parameter int          CLEAR_ON_RESET = 1,
  parameter logic [15:0] FILL_DEFAULT   = 16'h0720
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [13:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [11:0] I_text_char_addr,
  output logic [7:0]  O_text_char_data,
  output logic [7:0]  O_text_attr_data,
  output logic [1:0]  O_pattern_mode,
  output logic        O_busy
);

  import text_pkg::*;

  localparam int                N_CELLS   = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(N_CELLS - 1);

  // Registered state
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fill_idx_q, fill_idx_d;
  logic [15:0]       fill_data_q, fill_data_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [1:0]        mode_q, mode_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_ok_q, ram_ok_d;
  logic              vid_ok_q, vid_ok_d;

  // Request decode
  logic              busy;
  logic              req;
  logic              is_reg;
  logic [2:0]        reg_off;
  logic              needs_ram;
  logic              accept;
  logic              cell_in_range;

  // RAM port A
  logic [1:0]        a_we;
  logic [1:0]        a_we_gated;
  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_wdata;
  logic [15:0]       a_rdata;
  logic [15:0]       b_rdata;

  // Byte lanes 3:2 and address bit 12 carry no meaning here
  logic              unused_ok;
  assign unused_ok = ^{wb_sel_i[3:2], wb_adr_i[12]};

  assign busy          = (state_q == ST_FILL);
  assign req           = wb_cyc_i & wb_stb_i & ~ack_q;
  assign is_reg        = wb_adr_i[13];
  assign reg_off       = wb_adr_i[2:0];
  assign needs_ram     = ~is_reg | (reg_off == REG_DATA);
  // RAM-touching accesses wait for the clear engine; register accesses do not
  assign accept        = req & ~(busy & needs_ram);
  assign cell_in_range = (wb_adr_i[11:0] <= LAST_CELL);

  // Clear engine next-state: start on CLEAR write, walk every cell once
  always_comb begin
    state_d     = state_q;
    fill_idx_d  = fill_idx_q;
    fill_data_d = fill_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_reg && wb_we_i && (reg_off == REG_CLEAR)) begin
          state_d     = ST_FILL;
          fill_idx_d  = '0;
          fill_data_d = wb_dat_i[15:0];
        end
      end
      ST_FILL: begin
        if (fill_idx_q == LAST_CELL) begin
          state_d = ST_IDLE;
        end else begin
          fill_idx_d = fill_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wishbone decode: registers, cursor, RAM port A requests
  always_comb begin
    ack_d    = accept;
    mode_d   = mode_q;
    cursor_d = cursor_q;
    dat_d    = '0;
    ram_rd_d = 1'b0;
    ram_ok_d = 1'b0;
    a_we     = 2'b00;
    a_addr   = is_reg ? cursor_q : wb_adr_i[11:0];
    a_wdata  = wb_dat_i[15:0];

    if (accept) begin
      if (is_reg) begin
        case (reg_off)
          REG_MODE: begin
            if (wb_we_i) mode_d = wb_dat_i[1:0];
            else         dat_d  = {30'b0, mode_q};
          end
          REG_CURSOR: begin
            if (wb_we_i) cursor_d = clamp_index(wb_dat_i, LAST_CELL);
            else         dat_d    = {20'b0, cursor_q};
          end
          REG_DATA: begin
            if (wb_we_i) begin
              a_we     = wb_sel_i[1:0];
              cursor_d = (cursor_q == LAST_CELL) ? '0 : cursor_q + 1'b1;
            end else begin
              ram_rd_d = 1'b1;
              ram_ok_d = 1'b1;
            end
          end
          REG_CLEAR: begin
            if (!wb_we_i) dat_d = {31'b0, busy};
          end
          default: ;
        endcase
      end else begin
        if (wb_we_i) begin
          a_we = cell_in_range ? wb_sel_i[1:0] : 2'b00;
        end else begin
          ram_rd_d = 1'b1;
          ram_ok_d = cell_in_range;
        end
      end
    end

    // The fill owns port A outright; no RAM access is accepted meanwhile
    if (state_q == ST_FILL) begin
      a_we    = 2'b11;
      a_addr  = fill_idx_q;
      a_wdata = fill_data_q;
    end
  end

  // No RAM writes while reset is held, so contents survive reset
  assign a_we_gated = I_rst ? 2'b00 : a_we;
  assign vid_ok_d   = (I_text_char_addr <= LAST_CELL);

  // State registers with synchronous reset
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_FILL : ST_IDLE;
      fill_idx_q  <= '0;
      fill_data_q <= FILL_DEFAULT;
      cursor_q    <= '0;
      mode_q      <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      ram_rd_q    <= 1'b0;
      ram_ok_q    <= 1'b0;
      vid_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_idx_q  <= fill_idx_d;
      fill_data_q <= fill_data_d;
      cursor_q    <= cursor_d;
      mode_q      <= mode_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      ram_rd_q    <= ram_rd_d;
      ram_ok_q    <= ram_ok_d;
      vid_ok_q    <= vid_ok_d;
    end
  end

  char_attr_dpram u_ram (
    .clk     (I_clk),
    .a_we    (a_we_gated),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_addr  (I_text_char_addr),
    .b_rdata (b_rdata)
  );

  // Read data is only driven during ack; RAM reads come straight from port A
  always_comb begin
    wb_dat_o = '0;
    if (ack_q) begin
      if (ram_rd_q) wb_dat_o = ram_ok_q ? {16'b0, a_rdata} : 32'b0;
      else          wb_dat_o = dat_q;
    end
  end

  assign wb_ack_o         = ack_q;
  assign O_pattern_mode   = mode_q;
  assign O_busy           = busy;
  assign O_text_char_data = vid_ok_q ? b_rdata[7:0]  : 8'h00;
  assign O_text_attr_data = vid_ok_q ? b_rdata[15:8] : 8'h00;

endmodule

// File: tb/tb_wb_text_ram.sv
// Directed bench: instance 0 clears on reset, instance 1 does not.
module tb_wb_text_ram;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic [13:0] wb_adr   [2];
  logic [31:0] wb_dat_w [2];
  logic [31:0] wb_dat_r [2];
  logic        wb_we    [2];
  logic [3:0]  wb_sel   [2];
  logic        wb_stb   [2];
  logic        wb_cyc   [2];
  logic        wb_ack   [2];
  logic [11:0] vaddr    [2];
  logic [7:0]  vchar    [2];
  logic [7:0]  vattr    [2];
  logic [1:0]  pmode    [2];
  logic        busy     [2];

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [13:0] A_MODE   = 14'h2000;
  localparam logic [13:0] A_CURSOR = 14'h2001;
  localparam logic [13:0] A_DATA   = 14'h2002;
  localparam logic [13:0] A_CLEAR  = 14'h2003;
  localparam logic [13:0] A_REG6   = 14'h2006;

  wb_text_ram #(.COLS(80), .ROWS(30), .CLEAR_ON_RESET(1), .FILL_DEFAULT(16'h0720)) u_dut (
    .I_clk(clk), .I_rst(rst[0]),
    .wb_adr_i(wb_adr[0]), .wb_dat_i(wb_dat_w[0]), .wb_dat_o(wb_dat_r[0]),
    .wb_we_i(wb_we[0]), .wb_sel_i(wb_sel[0]), .wb_stb_i(wb_stb[0]),
    .wb_cyc_i(wb_cyc[0]), .wb_ack_o(wb_ack[0]),
    .I_text_char_addr(vaddr[0]), .O_text_char_data(vchar[0]), .O_text_attr_data(vattr[0]),
    .O_pattern_mode(pmode[0]), .O_busy(busy[0])
  );

  wb_text_ram #(.COLS(80), .ROWS(30), .CLEAR_ON_RESET(0), .FILL_DEFAULT(16'h0720)) u_dut_nc (
    .I_clk(clk), .I_rst(rst[1]),
    .wb_adr_i(wb_adr[1]), .wb_dat_i(wb_dat_w[1]), .wb_dat_o(wb_dat_r[1]),
    .wb_we_i(wb_we[1]), .wb_sel_i(wb_sel[1]), .wb_stb_i(wb_stb[1]),
    .wb_cyc_i(wb_cyc[1]), .wb_ack_o(wb_ack[1]),
    .I_text_char_addr(vaddr[1]), .O_text_char_data(vchar[1]), .O_text_attr_data(vattr[1]),
    .O_pattern_mode(pmode[1]), .O_busy(busy[1])
  );

  // One Wishbone transfer; returns read data and cycles until ack
  task automatic wb_xfer(input int d, input logic [13:0] adr, input logic [31:0] dat,
                         input logic we, input logic [3:0] sel,
                         output logic [31:0] rd, output int waits);
    @(negedge clk);
    wb_adr[d] = adr; wb_dat_w[d] = dat; wb_we[d] = we; wb_sel[d] = sel;
    wb_cyc[d] = 1'b1; wb_stb[d] = 1'b1;
    waits = 0;
    rd = '0;
    while (1) begin
      @(negedge clk);
      waits++;
      if (wb_ack[d] === 1'b1) begin
        rd = wb_dat_r[d];
        break;
      end
      if (waits >= 5000) break;
    end
    if (wb_ack[d] !== 1'b1) begin
      n_total++;
      $display("FAIL wb_timeout dut%0d adr=%h: no ack after %0d cycles, required ack", d, adr, waits);
    end
    wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0; wb_we[d] = 1'b0;
    $display("wb dut%0d %s adr=%h dat=%h sel=%b rd=%h waits=%0d",
             d, we ? "WR" : "RD", adr, dat, sel, rd, waits);
  endtask

  // Present a video index and sample one cycle later
  task automatic vid_read(input int d, input logic [11:0] a,
                          output logic [7:0] c, output logic [7:0] at);
    @(negedge clk);
    vaddr[d] = a;
    @(negedge clk);
    c  = vchar[d];
    at = vattr[d];
  endtask

  task automatic test_reset();
    int cnt;
    logic [7:0] c, at;
    logic [11:0] addrs [3];
    addrs[0] = 12'd0; addrs[1] = 12'd1234; addrs[2] = 12'd2399;
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (wb_ack[0] !== 1'b0 || wb_dat_r[0] !== 32'h0 || pmode[0] !== 2'd0)
      $display("FAIL reset_bus ack=%b dat=%h mode=%0d required 0/0/0", wb_ack[0], wb_dat_r[0], pmode[0]);
    else n_pass++;
    n_total++;
    if (busy[0] !== 1'b1 || busy[1] !== 1'b0)
      $display("FAIL reset_busy got %b/%b required 1/0", busy[0], busy[1]);
    else n_pass++;
    n_total++;
    if (vchar[0] !== 8'h00 || vattr[0] !== 8'h00)
      $display("FAIL reset_video got %h/%h required 00/00", vchar[0], vattr[0]);
    else n_pass++;
    rst[0] = 1'b0; rst[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy[0] === 1'b1) cnt++;
      else break;
      @(negedge clk);
    end
    n_total++;
    if (cnt != 2400) $display("FAIL busy_length got %0d cycles required 2400", cnt);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      vid_read(0, addrs[k], c, at);
      n_total++;
      if (c !== 8'h20 || at !== 8'h07)
        $display("FAIL reset_fill cell %0d got %h/%h required 20/07", addrs[k], c, at);
      else n_pass++;
    end
  endtask

  task automatic test_cell_write();
    logic [31:0] rd;
    int w;
    logic [7:0] c, at;
    wb_xfer(0, 14'd5, 32'h0000_1E41, 1'b1, 4'b0011, rd, w);
    n_total++;
    if (w != 1) $display("FAIL write_ack_latency got %0d required 1", w);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (wb_ack[0] !== 1'b0) $display("FAIL ack_single_cycle got %b required 0", wb_ack[0]);
    else n_pass++;
    vid_read(0, 12'd5, c, at);
    n_total++;
    if (c !== 8'h41 || at !== 8'h1E) $display("FAIL video_cell5 got %h/%h required 41/1E", c, at);
    else n_pass++;
    wb_xfer(0, 14'd5, 32'h0000_0042, 1'b1, 4'b0001, rd, w);
    vid_read(0, 12'd5, c, at);
    n_total++;
    if (c !== 8'h42 || at !== 8'h1E) $display("FAIL byte_lane got %h/%h required 42/1E", c, at);
    else n_pass++;
    wb_xfer(0, 14'd5, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0000_1E42 || w != 1) $display("FAIL cell_read got %h/%0d required 00001E42/1", rd, w);
    else n_pass++;
  endtask

  task automatic test_cursor_wrap();
    logic [31:0] rd;
    int w;
    wb_xfer(0, A_CURSOR, 32'd4000, 1'b1, 4'b1111, rd, w);
    wb_xfer(0, A_CURSOR, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'd2399) $display("FAIL cursor_clamp got %0d required 2399", rd);
    else n_pass++;
    wb_xfer(0, A_CURSOR, 32'd2399, 1'b1, 4'b1111, rd, w);
    wb_xfer(0, A_DATA, 32'h0000_0F58, 1'b1, 4'b0011, rd, w);
    wb_xfer(0, A_DATA, 32'h0000_0F59, 1'b1, 4'b0011, rd, w);
    wb_xfer(0, A_CURSOR, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'd1) $display("FAIL cursor_wrap got %0d required 1", rd);
    else n_pass++;
    wb_xfer(0, 14'd2399, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0000_0F58) $display("FAIL data_cell2399 got %h required 00000F58", rd);
    else n_pass++;
    wb_xfer(0, 14'd0, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0000_0F59) $display("FAIL data_cell0 got %h required 00000F59", rd);
    else n_pass++;
    wb_xfer(0, 14'd1, 32'h0000_0A31, 1'b1, 4'b0011, rd, w);
    wb_xfer(0, A_DATA, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0000_0A31) $display("FAIL data_read got %h required 00000A31", rd);
    else n_pass++;
    wb_xfer(0, A_CURSOR, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'd1) $display("FAIL data_read_no_inc got %0d required 1", rd);
    else n_pass++;
  endtask

  task automatic test_clear_stall();
    logic [31:0] rd;
    int w;
    logic [7:0] c, at;
    wb_xfer(0, A_CLEAR, 32'h0000_1F2E, 1'b1, 4'b1111, rd, w);
    wb_xfer(0, A_MODE, 32'd1, 1'b1, 4'b1111, rd, w);
    n_total++;
    if (w != 1 || busy[0] !== 1'b1 || pmode[0] !== 2'd1)
      $display("FAIL mode_during_fill waits=%0d busy=%b mode=%0d required 1/1/1", w, busy[0], pmode[0]);
    else n_pass++;
    wb_xfer(0, A_CLEAR, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'd1 || w != 1) $display("FAIL clear_status got %h/%0d required 1/1", rd, w);
    else n_pass++;
    wb_xfer(0, 14'd10, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (w < 2000 || busy[0] !== 1'b0)
      $display("FAIL cell_read_held waits=%0d busy=%b required >=2000/0", w, busy[0]);
    else n_pass++;
    n_total++;
    if (rd !== 32'h0000_1F2E) $display("FAIL cell_after_clear got %h required 00001F2E", rd);
    else n_pass++;
    vid_read(0, 12'd5, c, at);
    n_total++;
    if (c !== 8'h2E || at !== 8'h1F) $display("FAIL video_after_clear got %h/%h required 2E/1F", c, at);
    else n_pass++;
  endtask

  task automatic test_bounds();
    logic [31:0] rd;
    int w;
    logic [7:0] c, at;
    wb_xfer(0, A_MODE, 32'd3, 1'b1, 4'b1111, rd, w);
    @(negedge clk);
    n_total++;
    if (pmode[0] !== 2'd3) $display("FAIL mode_pin got %0d required 3", pmode[0]);
    else n_pass++;
    wb_xfer(0, 14'd2400, 32'h0000_BEEF, 1'b1, 4'b0011, rd, w);
    n_total++;
    if (w != 1) $display("FAIL oob_write_ack got %0d required 1", w);
    else n_pass++;
    wb_xfer(0, 14'd0, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0000_1F2E) $display("FAIL oob_write_alias got %h required 00001F2E", rd);
    else n_pass++;
    wb_xfer(0, 14'd3000, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0 || w != 1) $display("FAIL oob_read got %h/%0d required 0/1", rd, w);
    else n_pass++;
    wb_xfer(0, A_REG6, 32'hFFFF_FFFF, 1'b1, 4'b1111, rd, w);
    wb_xfer(0, A_REG6, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0 || w != 1) $display("FAIL reg6_read got %h/%0d required 0/1", rd, w);
    else n_pass++;
    vid_read(0, 12'd3000, c, at);
    n_total++;
    if (c !== 8'h00 || at !== 8'h00) $display("FAIL video_oob got %h/%h required 00/00", c, at);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd;
    int w;
    wb_xfer(1, 14'd100, 32'h0000_AAAA, 1'b1, 4'b0011, rd, w);
    wb_xfer(1, 14'd900, 32'h0000_5555, 1'b1, 4'b0011, rd, w);
    wb_xfer(1, A_MODE, 32'd2, 1'b1, 4'b1111, rd, w);
    wb_xfer(1, A_CURSOR, 32'd77, 1'b1, 4'b1111, rd, w);
    wb_xfer(1, A_CLEAR, 32'h0000_0C33, 1'b1, 4'b1111, rd, w);
    repeat (498) @(negedge clk);
    n_total++;
    if (busy[1] !== 1'b1) $display("FAIL fill_running got %b required 1", busy[1]);
    else n_pass++;
    rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy[1] !== 1'b0 || pmode[1] !== 2'd0)
      $display("FAIL abort_state busy=%b mode=%0d required 0/0", busy[1], pmode[1]);
    else n_pass++;
    wb_xfer(1, A_CURSOR, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'd0) $display("FAIL abort_cursor got %0d required 0", rd);
    else n_pass++;
    wb_xfer(1, 14'd100, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0000_0C33) $display("FAIL abort_cell100 got %h required 00000C33", rd);
    else n_pass++;
    wb_xfer(1, 14'd900, 32'h0, 1'b0, 4'b1111, rd, w);
    n_total++;
    if (rd !== 32'h0000_5555) $display("FAIL abort_cell900 got %h required 00005555", rd);
    else n_pass++;
    n_total++;
    if (busy[1] !== 1'b0) $display("FAIL no_restart got %b required 0", busy[1]);
    else n_pass++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; wb_adr[d] = '0; wb_dat_w[d] = '0; wb_we[d] = 1'b0;
      wb_sel[d] = 4'b0; wb_stb[d] = 1'b0; wb_cyc[d] = 1'b0; vaddr[d] = '0;
    end
    test_reset();
    test_cell_write();
    test_cursor_wrap();
    test_clear_stall();
    test_bounds();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
